// File: rtl/aes128_decrypt_core.sv
// aes128_decrypt_core: iterative AES-128 inverse cipher.
// Each clock applies one transformation: AddRoundKey, InvMixColumns,
// InvShiftRows or InvSubBytes. Round keys come from an already expanded
// 1408-bit key bus (rk0 at the MSBs).
module aes128_decrypt_core (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [127:0]   data_in,
  input  logic [1407:0]  w_all,
  input  logic [3:0]     key_ready_index,
  output logic [127:0]   data_out,
  output logic           busy,
  output logic           done
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAITKEY  = 3'd1,
    S_ADDKEY   = 3'd2,
    S_INVMIX   = 3'd3,
    S_INVSHIFT = 3'd4,
    S_INVSUB   = 3'd5
  } fsm_t;

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  fsm_t           fsm_q;
  fsm_t           fsm_d;
  logic [127:0]   state_reg;
  logic [3:0]     round;
  logic [10:0]    rk_base;
  logic [127:0]   round_key;
  logic [127:0]   add_rk;
  logic           key_ready;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Column mix with the inverse matrix {0e,0b,0d,09}, built from x2/x4/x8 terms.
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    logic [7:0]   m9 [4];
    logic [7:0]   mb [4];
    logic [7:0]   md [4];
    logic [7:0]   me [4];
    logic [7:0]   x2, x4, x8;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a[r]  = s[127-8*(4*c+r) -: 8];
        x2    = xtime(a[r]);
        x4    = xtime(x2);
        x8    = xtime(x4);
        m9[r] = x8 ^ a[r];
        mb[r] = x8 ^ x2 ^ a[r];
        md[r] = x8 ^ x4 ^ a[r];
        me[r] = x8 ^ x4 ^ x2;
      end
      o[127-32*c -: 8]  = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      o[119-32*c -: 8]  = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      o[111-32*c -: 8]  = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      o[103-32*c -: 8]  = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
    return o;
  endfunction

  // Row r of the column-major block rotated right by r byte positions.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  // Inverse S-box lookup on every byte of the block.
  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    end
    return o;
  endfunction

  // Select rk[round] from the expanded key; round never exceeds 10.
  always_comb begin
    rk_base   = 11'd1407 - {round, 7'b0};
    round_key = w_all[rk_base -: 128];
    add_rk    = state_reg ^ round_key;
    key_ready = (key_ready_index >= 4'd11);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fsm_q <= S_IDLE;
    else      fsm_q <= fsm_d;
  end

  // Next-state logic: ADD(10), then SHIFT/SUB/ADD/MIX per round, ending in ADD(0).
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE:     if (start) fsm_d = S_WAITKEY;
      S_WAITKEY:  if (key_ready) fsm_d = S_ADDKEY;
      S_ADDKEY: begin
        if (round == 4'd10)     fsm_d = S_INVSHIFT;
        else if (round == 4'd0) fsm_d = S_IDLE;
        else                    fsm_d = S_INVMIX;
      end
      S_INVMIX:   fsm_d = S_INVSHIFT;
      S_INVSHIFT: fsm_d = S_INVSUB;
      S_INVSUB:   fsm_d = S_ADDKEY;
      default:    fsm_d = S_IDLE;
    endcase
  end

  // FSM outputs: busy everywhere except idle.
  always_comb begin
    busy = (fsm_q != S_IDLE);
  end

  // Working block, round counter, result register and one-cycle done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= '0;
      round     <= '0;
      data_out  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm_q)
        S_IDLE: begin
          if (start) begin
            state_reg <= data_in;
            round     <= 4'd10;
          end
        end
        S_ADDKEY: begin
          state_reg <= add_rk;
          if (round == 4'd0) begin
            data_out <= add_rk;
            done     <= 1'b1;
          end
        end
        S_INVMIX:   state_reg <= inv_mix_columns(state_reg);
        S_INVSHIFT: state_reg <= inv_shift_rows(state_reg);
        S_INVSUB: begin
          state_reg <= inv_sub_bytes(state_reg);
          round     <= round - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_decrypt_core.sv
// Bench for aes128_decrypt_core: a forward AES-128 model (key expansion and
// encryption) produces ciphertexts; the scoreboard expects the plaintext back
// with the documented start-to-done latency.
module tb_aes128_decrypt_core;

  logic           clk;
  logic           rst;
  logic           start;
  logic [127:0]   data_in;
  logic [1407:0]  w_all;
  logic [3:0]     key_ready_index;
  logic [127:0]   data_out;
  logic           busy;
  logic           done;

  aes128_decrypt_core dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .w_all(w_all),
    .key_ready_index(key_ready_index), .data_out(data_out), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] exp;
    int           t0;
    int           lat;
  } item_t;

  item_t      sb_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [7:0] sbox [256];

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic init_sbox();
    logic [7:0] inv, b, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv; s = inv;
      for (int k = 0; k < 4; k++) begin
        b = {b[6:0], b[7]};
        s = s ^ b;
      end
      sbox[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] r;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    r = '0;
    for (int i = 0; i < 44; i++) r[1407-32*i -: 32] = w[i];
    return r;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1407:0] w);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] rk, o;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int r = 0; r <= 10; r++) begin
      if (r > 0) begin
        for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
        for (int c = 0; c < 4; c++)
          for (int rw = 0; rw < 4; rw++) t[c*4+rw] = s[((c+rw)%4)*4+rw];
        for (int i = 0; i < 16; i++) s[i] = t[i];
        if (r < 10) begin
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
            s[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
            s[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
            s[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
          end
        end
      end
      rk = w[1407-128*r -: 128];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- cycle counter and monitor ----------------
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin : monitor
    logic         prev_done;
    logic [127:0] last_out;
    item_t        it;
    int           lat;
    prev_done = 1'b0;
    last_out  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_done = 1'b0;
        last_out  = '0;
      end else begin
        if (done) begin
          total++;
          if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_done: got done with no block outstanding, data_out=%h", data_out);
          end else begin
            it  = sb_q.pop_front();
            lat = cyc - it.t0 + 1;
            if (data_out !== it.exp) begin
              bad++;
              $display("FAIL plaintext: got %h want %h", data_out, it.exp);
            end
            total++;
            if (lat != it.lat) begin
              bad++;
              $display("FAIL latency: got %0d want %0d", lat, it.lat);
            end
          end
          total++;
          if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_at_done: got %b want 0", busy);
          end
          total++;
          if (prev_done) begin
            bad++;
            $display("FAIL done_width: got done high two cycles, want one");
          end
          last_out = data_out;
        end else begin
          total++;
          if (data_out !== last_out) begin
            bad++;
            $display("FAIL data_out_hold: got %h want %h", data_out, last_out);
          end
        end
        prev_done = done;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic issue(input logic [127:0] ct, input logic [127:0] exp, input int lat);
    item_t it;
    data_in = ct;
    start   = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    it.exp = exp; it.t0 = cyc; it.lat = lat;
    sb_q.push_back(it);
    check("busy_after_start", {127'd0, busy}, 128'd1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d blocks outstanding want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0]  key_c1, ct_c1, pt_c1, key_b, ct_b, pt_b, pt2, key, pt;
    logic [1407:0] w_c1;
    key_c1 = 128'h000102030405060708090a0b0c0d0e0f;
    ct_c1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    pt_c1  = 128'h00112233445566778899aabbccddeeff;
    key_b  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    ct_b   = 128'h3925841d02dc09fbdc118597196a0b32;
    pt_b   = 128'h3243f6a8885a308d313198a2e0370734;

    rst = 1'b0; start = 1'b0; data_in = '0; w_all = '0; key_ready_index = 4'd0;
    init_sbox();
    w_c1 = expand(key_c1);
    repeat (3) @(posedge clk);
    #1;
    check("reset_data_out", data_out, 128'd0);
    check("reset_busy", {127'd0, busy}, 128'd0);
    check("reset_done", {127'd0, done}, 128'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 C.1
    w_all = w_c1; key_ready_index = 4'd11;
    issue(ct_c1, pt_c1, 42);
    drain(200);

    // FIPS-197 Appendix B
    w_all = expand(key_b);
    issue(ct_b, pt_b, 42);
    drain(200);

    // Key wait: only 5 keys for 20 cycles
    w_all = w_c1; key_ready_index = 4'd5;
    issue(ct_c1, pt_c1, 62);
    repeat (20) @(posedge clk);
    #1;
    check("busy_in_keywait", {127'd0, busy}, 128'd1);
    key_ready_index = 4'd11;
    drain(200);

    // Start while busy is ignored
    issue(ct_c1, pt_c1, 42);
    repeat (4) @(posedge clk);
    #1; data_in = ct_b; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (24) @(posedge clk);
    #1; data_in = ~ct_c1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    drain(200);
    repeat (50) @(posedge clk);
    #1;

    // Back-to-back with start held high
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    data_in = ct_c1; start = 1'b1;
    @(posedge clk); #1;
    begin
      item_t it;
      it.exp = pt_c1; it.t0 = cyc; it.lat = 42;
      sb_q.push_back(it);
      data_in = encrypt(pt2, w_c1);
      repeat (42) @(posedge clk);
      #1;
      it.exp = pt2; it.t0 = cyc; it.lat = 42;
      sb_q.push_back(it);
      start = 1'b0;
    end
    drain(200);

    // Reset mid-operation
    issue(ct_c1, pt_c1, 42);
    repeat (19) @(posedge clk);
    #1; rst = 1'b0;
    #1;
    check("midreset_data_out", data_out, 128'd0);
    check("midreset_busy", {127'd0, busy}, 128'd0);
    check("midreset_done", {127'd0, done}, 128'd0);
    sb_q.delete();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    issue(ct_c1, pt_c1, 42);
    drain(200);

    // Random round trips
    for (int n = 0; n < 100; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      w_all = expand(key);
      key_ready_index = 4'(11 + $urandom_range(0, 4));
      issue(encrypt(pt, w_all), pt, 42);
      drain(200);
    end

    repeat (5) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes128_decrypt_core.md
# aes128_decrypt_core

Iterative AES-128 inverse cipher (FIPS-197 §5.3). It converts one 128-bit ciphertext block to plaintext using the eleven round keys produced by the team's existing key-schedule block. The inverse cipher runs one transformation per clock. The block sits beside the encrypt datapath, shares the same round-key bus format, and adds a start/busy/done handshake so a host can stream blocks back-to-back.

## Interface
- No parameters. Fixed at AES-128: 10 rounds, 11 round keys.
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  request a decryption; sampled only in S_IDLE
- data_in  in  128  ciphertext; byte 0 is [127:120]; captured on the accepted start edge
- w_all  in  1408  expanded key; round key r = w_all[1407-128*r -: 128] (rk0 at the MSBs)
- key_ready_index  in  4  number of round keys valid in w_all (0..11)
- data_out  out  128  plaintext; holds the last result until the next completion
- busy  out  1  high in every state except S_IDLE
- done  out  1  one-cycle pulse; data_out is valid in the same cycle

## Operation
- Registers:
  - state_reg [127:0]: working block
  - round [3:0]: counts down 10→0
  - FSM state [2:0]
- Combinational sub-functions, each operating on state_reg:
  - InvShiftRows: row n rotated right by n bytes
  - InvSubBytes: inverse S-box applied to all 16 bytes
  - InvMixColumns: matrix {0e,0b,0d,09}, GF(2^8) modulo x^8+x^4+x^3+x+1
  - AddRoundKey: XOR with rk[round]
- FSM states and transitions:
  - S_IDLE: if start, then state_reg←data_in, round←10, go to S_WAITKEY; otherwise stay.
  - S_WAITKEY: if key_ready_index ≥ 11, go to S_ADDKEY; otherwise stay. All 11 keys are required because rk10 is used first.
  - S_ADDKEY: state_reg←state_reg^rk[round].
    - round==10: go to S_INVSHIFT.
    - round 9..1: go to S_INVMIX.
    - round==0: data_out←result, done←1, go to S_IDLE.
  - S_INVMIX: state_reg←InvMixColumns; go to S_INVSHIFT.
  - S_INVSHIFT: state_reg←InvShiftRows; go to S_INVSUB.
  - S_INVSUB: state_reg←InvSubBytes, round←round-1; go to S_ADDKEY.
- Resulting sequence:
  - ADD(10)
  - then ×9: SHIFT, SUB, ADD(r), MIX for r=9..1
  - then SHIFT, SUB, ADD(0)
- round never underflows: S_INVSUB is unreachable with round==0.
- start while busy is ignored and not queued.
- w_all and key_ready_index are sampled continuously. The caller must hold the key stable from the start edge until done. If the key changes mid-operation, the result is undefined.
- key_ready_index values above 11 are treated as ready.

## Timing
- Reset (asynchronous assert, synchronous release): S_IDLE, round=0, state_reg=0, data_out=0, busy=0, done=0.
- Reset asserted mid-operation aborts the block immediately with the values above. No done pulse is generated.
- With keys already ready, start sampled at edge T0 gives:
  - S_WAITKEY in cycle T0+1
  - first S_ADDKEY at T0+2
  - 40 transform cycles
  - final ADDKEY at edge T0+41; done=1 and data_out valid during cycle T0+42
- Total: 42 cycles start→done. Each extra cycle spent in S_WAITKEY adds one cycle.
- busy rises the cycle after the start edge and falls in the same cycle done rises.
- done is high for exactly one cycle.
- Back-to-back operation: start held high during the done cycle is accepted, since the FSM is in S_IDLE. Throughput is one block per 42 cycles.
- data_out changes only at a completion edge or at reset.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a → data_out 00112233445566778899aabbccddeeff; done exactly 42 cycles after start.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 → 3243f6a8885a308d313198a2e0370734.
- Key wait: hold key_ready_index=5 for 20 cycles after start, then 11 → FSM stays in S_WAITKEY throughout; done arrives at 42+20 cycles; C.1 result is correct.
- Busy rejection: pulse start with a different data_in at cycles 5 and 30 of an operation → exactly one done; result matches the first block only. Back-to-back: start held high → two dones 42 cycles apart.
- Reset mid-operation: assert rst at cycle 20 → data_out=0, busy=0, done=0 immediately. After release, a new C.1 run completes correctly.
- Round-trip: 100 random key/plaintext pairs encrypted by the team's encrypt block, then decrypted here → original plaintext recovered every time.
